seq_stim_ctrl: RTL and testbench

Stimulus controller for the lab's sequence detector. It latches a bit pattern from switches and feeds it into the detector one bit per advance, either free-running on a slow tick or one bit per debounced step pulse. It also counts detector hits. It sits between the clock divider / one-shot and the sequence detector in the top level, and replaces direct switch drive of X and the detector clock with a single-clock enable scheme.

---
 rtl/seq_pkg.sv | 21 ++
 rtl/sat_counter.sv | 34 +++
 rtl/seq_stim_ctrl.sv | 112 +++++++++++
 tb/tb_seq_stim_ctrl.sv | 273 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/seq_pkg.sv
// ============================================================================
// Module   : seq_pkg
// Purpose  : Shared state encoding and default widths for the stimulus controller
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

package seq_pkg;

    localparam logic [2:0] S_IDLE   = 3'd0;
    localparam logic [2:0] S_READY  = 3'd1;
    localparam logic [2:0] S_ISSUE  = 3'd2;
    localparam logic [2:0] S_SAMPLE = 3'd3;
    localparam logic [2:0] S_DONE   = 3'd4;

    localparam int PAT_W_DEF = 8;
    localparam int CNT_W_DEF = 8;

endpackage

`default_nettype wire

// File: rtl/sat_counter.sv
// ============================================================================
// Module   : sat_counter
// Purpose  : Up counter with synchronous clear that sticks at its maximum value
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module sat_counter #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         clr,
    input  logic         inc,
    output logic [W-1:0] q
);

    logic [W-1:0] r_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_q <= '0;
        end else if (clr) begin
            r_q <= '0;
        end else if (inc && (r_q != '1)) begin
            r_q <= r_q + 1'b1;
        end
    end

    assign q = r_q;

endmodule

`default_nettype wire

// File: rtl/seq_stim_ctrl.sv
// ============================================================================
// Module   : seq_stim_ctrl
// Purpose  : Latches a switch pattern and feeds it bit-serially to the sequence
//            detector on tick or step, counting detector hits
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module seq_stim_ctrl
    import seq_pkg::*;
#(
    parameter int PAT_W = PAT_W_DEF,
    parameter int IDX_W = 3,
    parameter int CNT_W = CNT_W_DEF
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             tick,
    input  logic             step,
    input  logic             run,
    input  logic             load,
    input  logic [PAT_W-1:0] pattern,
    input  logic [IDX_W:0]   len,
    input  logic             Z,
    output logic             X,
    output logic             adv,
    output logic             det_clr,
    output logic [IDX_W-1:0] bit_idx,
    output logic             busy,
    output logic             done,
    output logic [CNT_W-1:0] hits
);

    localparam logic [IDX_W:0] LEN_FULL = PAT_W[IDX_W:0];

    logic [2:0]       r_state;
    logic [2:0]       w_state_nxt;
    logic [PAT_W-1:0] r_pat;
    logic [IDX_W:0]   r_len;
    logic [IDX_W-1:0] r_idx;
    logic             r_det_clr;

    logic             w_trig;
    logic [IDX_W:0]   w_len_eff;
    logic             w_last;
    logic             w_in_bit;
    logic             w_hit;

    // The unselected trigger source is simply never looked at.
    assign w_trig    = run ? tick : step;
    assign w_len_eff = ((len == '0) || (len > LEN_FULL)) ? LEN_FULL : len;
    assign w_last    = (({1'b0, r_idx} + (IDX_W+1)'(1)) == r_len);

    always_comb begin
        w_state_nxt = r_state;
        if (load) begin
            w_state_nxt = S_READY;
        end else begin
            case (r_state)
                S_IDLE:   w_state_nxt = S_IDLE;
                S_READY:  w_state_nxt = w_trig ? S_ISSUE : S_READY;
                S_ISSUE:  w_state_nxt = S_SAMPLE;
                S_SAMPLE: w_state_nxt = w_last ? S_DONE : S_READY;
                S_DONE:   w_state_nxt = S_DONE;
                default:  w_state_nxt = S_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state   <= S_IDLE;
            r_pat     <= '0;
            r_len     <= '0;
            r_idx     <= '0;
            r_det_clr <= 1'b0;
        end else begin
            r_state   <= w_state_nxt;
            r_det_clr <= load;
            if (load) begin
                r_pat <= pattern;
                r_len <= w_len_eff;
                r_idx <= '0;
            end else if (r_state == S_SAMPLE) begin
                r_idx <= r_idx + 1'b1;
            end
        end
    end

    // X is held through SAMPLE so a Mealy Z stays valid while it is sampled.
    assign w_in_bit = (r_state == S_ISSUE) || (r_state == S_SAMPLE);
    assign X        = w_in_bit & r_pat[r_idx];
    assign adv      = (r_state == S_ISSUE);
    assign busy     = (r_state == S_READY) || w_in_bit;
    assign done     = (r_state == S_DONE);
    assign bit_idx  = r_idx;
    assign det_clr  = r_det_clr;
    assign w_hit    = (r_state == S_SAMPLE) && Z;

    sat_counter #(
        .W (CNT_W)
    ) u_hits (
        .clk   (clk),
        .reset (reset),
        .clr   (load),
        .inc   (w_hit),
        .q     (hits)
    );

endmodule

`default_nettype wire

// File: tb/tb_seq_stim_ctrl.sv
// ============================================================================
// Module   : tb_seq_stim_ctrl
// Purpose  : Directed and randomized bench for seq_stim_ctrl against a
//            per-bit behavioural model
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_seq_stim_ctrl;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       tick = 1'b0;
    logic       step = 1'b0;
    logic       run = 1'b0;
    logic       load = 1'b0;
    logic [7:0] pattern = 8'h00;
    logic [3:0] len = 4'd0;
    logic       Z = 1'b0;

    logic       X, adv, det_clr, busy, done;
    logic [2:0] bit_idx;
    logic [7:0] hits;
    logic       X2, adv2, det_clr2, busy2, done2;
    logic [2:0] bit_idx2;
    logic [1:0] hits2;

    always #5 clk = ~clk;

    seq_stim_ctrl u_dut (
        .clk(clk), .reset(reset), .tick(tick), .step(step), .run(run),
        .load(load), .pattern(pattern), .len(len), .Z(Z),
        .X(X), .adv(adv), .det_clr(det_clr), .bit_idx(bit_idx),
        .busy(busy), .done(done), .hits(hits)
    );

    seq_stim_ctrl #(.CNT_W(2)) u_dut2 (
        .clk(clk), .reset(reset), .tick(tick), .step(step), .run(run),
        .load(load), .pattern(pattern), .len(len), .Z(Z),
        .X(X2), .adv(adv2), .det_clr(det_clr2), .bit_idx(bit_idx2),
        .busy(busy2), .done(done2), .hits(hits2)
    );

    int  n_chk = 0;
    int  n_err = 0;
    bit  chk_en = 1'b0;
    int  adv_cnt = 0;
    int  xn = 0;
    logic xs [0:15];

    // Model: a pattern is either absent, being sent, or finished; each bit
    // goes through a 2-cycle window (present, then sample) after its trigger.
    bit         m_loaded = 1'b0;
    bit         m_done = 1'b0;
    bit         m_clr = 1'b0;
    int         m_phase = 0;
    logic [7:0] m_pat = 8'h00;
    int         m_len = 0;
    int         m_idx = 0;
    int         m_hits = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    initial begin
        forever begin
            @(posedge clk);
            if (reset) begin
                m_loaded = 1'b0; m_done = 1'b0; m_clr = 1'b0; m_phase = 0;
                m_pat = 8'h00; m_len = 0; m_idx = 0; m_hits = 0;
            end else if (load) begin
                m_loaded = 1'b1; m_done = 1'b0; m_clr = 1'b1; m_phase = 0;
                m_pat = pattern;
                m_len = (len == 0 || len > 8) ? 8 : int'(len);
                m_idx = 0; m_hits = 0;
            end else begin
                m_clr = 1'b0;
                if (m_phase == 1) begin
                    m_phase = 2;
                end else if (m_phase == 2) begin
                    if (Z) m_hits = m_hits + 1;
                    if (m_idx + 1 == m_len) m_done = 1'b1;
                    m_idx = (m_idx + 1) % 8;
                    m_phase = 0;
                end else if (m_loaded && !m_done && (run ? tick : step)) begin
                    m_phase = 1;
                end
            end
        end
    end

    initial begin
        forever begin
            @(negedge clk);
            if (chk_en) begin
                logic ex;
                ex = (m_phase != 0) ? m_pat[m_idx] : 1'b0;
                chk("X", X, ex);
                chk("adv", adv, (m_phase == 1));
                chk("det_clr", det_clr, m_clr);
                chk("bit_idx", bit_idx, m_idx);
                chk("busy", busy, (m_loaded && !m_done));
                chk("done", done, m_done);
                chk("hits", hits, (m_hits > 255) ? 255 : m_hits);
                chk("X2", X2, ex);
                chk("adv2", adv2, (m_phase == 1));
                chk("det_clr2", det_clr2, m_clr);
                chk("bit_idx2", bit_idx2, m_idx);
                chk("busy2", busy2, (m_loaded && !m_done));
                chk("done2", done2, m_done);
                chk("hits2", hits2, (m_hits > 3) ? 3 : m_hits);
                if (adv) begin
                    if (xn < 16) xs[xn] = X;
                    xn++;
                    adv_cnt++;
                end
            end
        end
    end

    task automatic cyc(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic do_load(input logic [7:0] p, input logic [3:0] l);
        pattern = p; len = l; load = 1'b1;
        cyc(1);
        load = 1'b0;
    endtask

    task automatic do_step();
        step = 1'b1; cyc(1); step = 1'b0;
    endtask

    task automatic do_tick();
        tick = 1'b1; cyc(1); tick = 1'b0;
    endtask

    int t1_exp [8] = '{0, 1, 0, 0, 1, 1, 0, 1};
    int t5_exp [6] = '{1, 2, 3, 3, 3, 3};

    initial begin
        cyc(1);
        chk_en = 1'b1;
        cyc(1);
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_adv", adv, 0);
        chk("rst_bit_idx", bit_idx, 0);
        chk("rst_hits", hits, 0);
        reset = 1'b0;
        cyc(2);

        // Step mode, 8 bits, LSB first
        run = 1'b0; Z = 1'b0;
        do_load(8'b1011_0010, 4'd8);
        chk("t1_det_clr", det_clr, 1);
        chk("t1_busy", busy, 1);
        adv_cnt = 0; xn = 0;
        for (int i = 0; i < 8; i++) begin
            do_step();
            if (i == 0) chk("t1_adv_latency", adv, 1);
            cyc(4);
        end
        chk("t1_adv_cnt", adv_cnt, 8);
        for (int i = 0; i < 8; i++) chk($sformatf("t1_x%0d", i), xs[i], t1_exp[i]);
        chk("t1_done", done, 1);
        chk("t1_busy_end", busy, 0);

        // Free-run, len 4, Z=1, extra ticks after done
        run = 1'b1; Z = 1'b1;
        do_load(8'hFF, 4'd4);
        adv_cnt = 0;
        repeat (6) begin
            do_tick();
            cyc(9);
        end
        chk("t2_adv_cnt", adv_cnt, 4);
        chk("t2_hits", hits, 4);
        chk("t2_hits2", hits2, 3);
        chk("t2_done", done, 1);

        // len=0 means full width
        run = 1'b0; Z = 1'b0;
        do_load(8'h01, 4'd0);
        adv_cnt = 0;
        repeat (10) begin
            do_step();
            cyc(4);
        end
        chk("t3_adv_cnt", adv_cnt, 8);
        chk("t3_done", done, 1);

        // load and trigger together during SAMPLE
        Z = 1'b1;
        do_load(8'hFF, 4'd8);
        do_step(); cyc(4);
        chk("t4_hits_pre", hits, 1);
        chk("t4_idx_pre", bit_idx, 1);
        do_step(); cyc(1);
        load = 1'b1; step = 1'b1; pattern = 8'hFF; len = 4'd8;
        cyc(1);
        load = 1'b0; step = 1'b0;
        chk("t4_idx", bit_idx, 0);
        chk("t4_hits", hits, 0);
        chk("t4_det_clr", det_clr, 1);
        chk("t4_adv", adv, 0);
        chk("t4_busy", busy, 1);
        cyc(1);
        chk("t4_det_clr_once", det_clr, 0);
        chk("t4_adv_next", adv, 0);

        // Saturation on the 2-bit counter
        Z = 1'b1;
        do_load(8'hFF, 4'd8);
        for (int i = 0; i < 6; i++) begin
            do_step();
            cyc(3);
            chk($sformatf("t5_hits2_%0d", i), hits2, t5_exp[i]);
        end

        // Ticks ignored in step mode; reset during ISSUE
        run = 1'b0; Z = 1'b0;
        do_load(8'hFF, 4'd8);
        adv_cnt = 0;
        repeat (5) begin
            do_tick();
            cyc(3);
        end
        chk("t6_adv_cnt", adv_cnt, 0);
        do_step();
        chk("t6_adv_issue", adv, 1);
        reset = 1'b1;
        cyc(1);
        reset = 1'b0;
        chk("t6_X", X, 0);
        chk("t6_adv", adv, 0);
        chk("t6_det_clr", det_clr, 0);
        chk("t6_busy", busy, 0);
        chk("t6_done", done, 0);
        chk("t6_bit_idx", bit_idx, 0);
        chk("t6_hits", hits, 0);

        // Randomized traffic
        for (int c = 0; c < 4000; c++) begin
            reset   = ($urandom_range(0, 599) == 0);
            load    = ($urandom_range(0, 59) == 0);
            pattern = 8'($urandom);
            len     = 4'($urandom_range(0, 15));
            tick    = ($urandom_range(0, 3) == 0);
            step    = ($urandom_range(0, 3) == 0);
            if ($urandom_range(0, 39) == 0) run = ~run;
            Z       = 1'($urandom_range(0, 1));
            cyc(1);
        end
        reset = 1'b0; load = 1'b0; tick = 1'b0; step = 1'b0;
        cyc(3);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule

`default_nettype wire
